// File: rtl/reg_file_param_if.sv
// reg_file_param_if
//   Bundles the write, read, issue and busy signals of reg_file_param.
//   Port summary (from the register file's point of view):
//     WRITE_EN, INaddr, IN      write strobe, address and data
//     OUT1addr, OUT2addr        read addresses
//     OUT1, OUT2                read data (combinational)
//     ISSUE_EN, ISSUEaddr       issue strobe and destination register
//     BUSY1, BUSY2              busy flags of the two read addresses
//     BUSY_VEC                  all busy flags, bit i = register i
//   master: decode/writeback side, slave: the register file.
interface reg_file_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
);
  logic              WRITE_EN;
  logic [ADDR_W-1:0] INaddr;
  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] OUT1addr;
  logic [ADDR_W-1:0] OUT2addr;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              ISSUE_EN;
  logic [ADDR_W-1:0] ISSUEaddr;
  logic              BUSY1;
  logic              BUSY2;
  logic [DEPTH-1:0]  BUSY_VEC;

  modport master (
    output WRITE_EN, INaddr, IN, OUT1addr, OUT2addr, ISSUE_EN, ISSUEaddr,
    input  OUT1, OUT2, BUSY1, BUSY2, BUSY_VEC
  );

  modport slave (
    input  WRITE_EN, INaddr, IN, OUT1addr, OUT2addr, ISSUE_EN, ISSUEaddr,
    output OUT1, OUT2, BUSY1, BUSY2, BUSY_VEC
  );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param
//   Parametrised register file: two combinational read ports, one clocked
//   write port, optional same-cycle write-to-read bypass, optional
//   hardwired-zero register 0, and a per-register busy scoreboard used by
//   the control unit to spot read-after-write hazards on in-flight results.
//   Ports:
//     clk     rising-edge clock for all state
//     RESET   synchronous active-high reset (overrides write and issue)
//     rf      reg_file_param_if.slave bundle (write/read/issue/busy)
module reg_file_param #(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 8,
  parameter int                ADDR_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                BYPASS    = 1,
  parameter int                ZERO_REG  = 0
) (
  input logic             clk,
  input logic             RESET,
  reg_file_param_if.slave rf
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_live;
  logic              wr_allowed;
  logic              iss_allowed;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;

  // A write is "live" for bypass purposes only when reset is not pending;
  // reset wins over everything at the edge, so it must win here too.
  assign wr_live     = rf.WRITE_EN && !RESET;
  assign wr_allowed  = rf.WRITE_EN && !((ZERO_REG != 0) && (rf.INaddr == '0));
  assign iss_allowed = rf.ISSUE_EN && !((ZERO_REG != 0) && (rf.ISSUEaddr == '0));

  // Write clears the flag first, issue sets it after: on a same-address
  // collision the new issue wins and the register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (rf.WRITE_EN) busy_nxt[rf.INaddr] = 1'b0;
    if (iss_allowed) busy_nxt[rf.ISSUEaddr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      busy <= '0;
    end else begin
      if (wr_allowed) regs[rf.INaddr] <= rf.IN;
      busy <= busy_nxt;
    end
  end

  always_comb begin
    out1 = regs[rf.OUT1addr];
    if ((BYPASS != 0) && wr_live && (rf.INaddr == rf.OUT1addr)) out1 = rf.IN;
    if ((ZERO_REG != 0) && (rf.OUT1addr == '0)) out1 = '0;
  end

  always_comb begin
    out2 = regs[rf.OUT2addr];
    if ((BYPASS != 0) && wr_live && (rf.INaddr == rf.OUT2addr)) out2 = rf.IN;
    if ((ZERO_REG != 0) && (rf.OUT2addr == '0)) out2 = '0;
  end

  // Busy is never bypassed: a clearing write shows up from the next cycle.
  assign rf.OUT1     = out1;
  assign rf.OUT2     = out2;
  assign rf.BUSY1    = busy[rf.OUT1addr];
  assign rf.BUSY2    = busy[rf.OUT2addr];
  assign rf.BUSY_VEC = busy;

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param
//   Directed bench for reg_file_param using three instances:
//     dut_a  8x8, RESET_VAL=0,    BYPASS=1, ZERO_REG=0
//     dut_b  8x8, RESET_VAL=8'h88, BYPASS=0, ZERO_REG=0
//     dut_c  16x16, RESET_VAL=0,  BYPASS=1, ZERO_REG=1
module tb_reg_file_param;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_W(8),  .DEPTH(8),  .ADDR_W(3)) ia ();
  reg_file_param_if #(.DATA_W(8),  .DEPTH(8),  .ADDR_W(3)) ib ();
  reg_file_param_if #(.DATA_W(16), .DEPTH(16), .ADDR_W(4)) ic ();

  reg_file_param #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .RESET_VAL(8'h00),
                   .BYPASS(1), .ZERO_REG(0))
    dut_a (.clk(clk), .RESET(rst_a), .rf(ia));
  reg_file_param #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .RESET_VAL(8'h88),
                   .BYPASS(0), .ZERO_REG(0))
    dut_b (.clk(clk), .RESET(rst_b), .rf(ib));
  reg_file_param #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .RESET_VAL(16'h0000),
                   .BYPASS(1), .ZERO_REG(1))
    dut_c (.clk(clk), .RESET(rst_c), .rf(ic));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ia.WRITE_EN = 0; ia.ISSUE_EN = 0; ia.INaddr = 0; ia.IN = 0;
    ia.OUT1addr = 0; ia.OUT2addr = 0; ia.ISSUEaddr = 0;
    ib.WRITE_EN = 0; ib.ISSUE_EN = 0; ib.INaddr = 0; ib.IN = 0;
    ib.OUT1addr = 0; ib.OUT2addr = 0; ib.ISSUEaddr = 0;
    ic.WRITE_EN = 0; ic.ISSUE_EN = 0; ic.INaddr = 0; ic.IN = 0;
    ic.OUT1addr = 0; ic.OUT2addr = 0; ic.ISSUEaddr = 0;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1; rst_c = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      ia.OUT1addr = i[2:0]; ia.OUT2addr = 3'(7 - i);
      ib.OUT1addr = i[2:0]; ib.OUT2addr = 3'(7 - i);
      #1;
      checks++;
      if (ia.OUT1 !== 8'h00 || ia.OUT2 !== 8'h00)
        $display("FAIL reset_a addr %0d: got %h/%h want 00/00", i, ia.OUT1, ia.OUT2);
      else passed++;
      checks++;
      if (ib.OUT1 !== 8'h88 || ib.OUT2 !== 8'h88)
        $display("FAIL reset_b addr %0d: got %h/%h want 88/88", i, ib.OUT1, ib.OUT2);
      else passed++;
    end
    checks++;
    if (ia.BUSY_VEC !== 8'h00 || ib.BUSY_VEC !== 8'h00 || ic.BUSY_VEC !== 16'h0000)
      $display("FAIL reset_busy: got %h %h %h want 0", ia.BUSY_VEC, ib.BUSY_VEC, ic.BUSY_VEC);
    else passed++;
    rst_a = 0; rst_b = 0; rst_c = 0;
    tick();
  endtask

  task automatic test_write_read();
    ia.WRITE_EN = 1; ia.INaddr = 5; ia.IN = 8'h97;
    tick();
    ia.INaddr = 2; ia.IN = 8'h3C;
    tick();
    ia.WRITE_EN = 0; ia.OUT1addr = 5; ia.OUT2addr = 2;
    #1;
    checks++;
    if (ia.OUT1 !== 8'h97 || ia.OUT2 !== 8'h3C)
      $display("FAIL write_read: got %h/%h want 97/3c", ia.OUT1, ia.OUT2);
    else passed++;
    ia.INaddr = 5; ia.IN = 8'h11;
    tick();
    checks++;
    if (ia.OUT1 !== 8'h97)
      $display("FAIL write_disabled: got %h want 97", ia.OUT1);
    else passed++;
  endtask

  task automatic test_bypass();
    ia.WRITE_EN = 1; ia.INaddr = 3; ia.IN = 8'hA5; ia.OUT1addr = 3; ia.OUT2addr = 3;
    ib.WRITE_EN = 1; ib.INaddr = 3; ib.IN = 8'hA5; ib.OUT1addr = 3; ib.OUT2addr = 3;
    #1;
    checks++;
    if (ia.OUT1 !== 8'hA5 || ia.OUT2 !== 8'hA5)
      $display("FAIL bypass_on: got %h/%h want a5/a5", ia.OUT1, ia.OUT2);
    else passed++;
    checks++;
    if (ib.OUT1 !== 8'h88 || ib.OUT2 !== 8'h88)
      $display("FAIL bypass_off_before: got %h/%h want 88/88", ib.OUT1, ib.OUT2);
    else passed++;
    tick();
    ia.WRITE_EN = 0; ib.WRITE_EN = 0;
    #1;
    checks++;
    if (ib.OUT1 !== 8'hA5 || ib.OUT2 !== 8'hA5 || ia.OUT1 !== 8'hA5)
      $display("FAIL bypass_after: got b %h/%h a %h want a5", ib.OUT1, ib.OUT2, ia.OUT1);
    else passed++;
    // Ports bypass independently.
    ia.WRITE_EN = 1; ia.INaddr = 3; ia.IN = 8'h5A; ia.OUT1addr = 3; ia.OUT2addr = 5;
    #1;
    checks++;
    if (ia.OUT1 !== 8'h5A || ia.OUT2 !== 8'h97)
      $display("FAIL bypass_one_port: got %h/%h want 5a/97", ia.OUT1, ia.OUT2);
    else passed++;
    tick();
    ia.WRITE_EN = 0;
  endtask

  task automatic test_scoreboard();
    ia.ISSUE_EN = 1; ia.ISSUEaddr = 4; ia.OUT1addr = 4;
    #1;
    checks++;
    if (ia.BUSY1 !== 1'b0)
      $display("FAIL busy_before_issue_edge: got %b want 0", ia.BUSY1);
    else passed++;
    tick();
    ia.ISSUE_EN = 0;
    #1;
    checks++;
    if (ia.BUSY_VEC !== 8'h10 || ia.BUSY1 !== 1'b1)
      $display("FAIL busy_issue: got vec %h busy1 %b want 10/1", ia.BUSY_VEC, ia.BUSY1);
    else passed++;
    ia.WRITE_EN = 1; ia.INaddr = 4; ia.IN = 8'h42;
    #1;
    checks++;
    if (ia.BUSY1 !== 1'b1 || ia.BUSY_VEC !== 8'h10)
      $display("FAIL busy_no_bypass: got busy1 %b vec %h want 1/10", ia.BUSY1, ia.BUSY_VEC);
    else passed++;
    tick();
    ia.WRITE_EN = 0;
    #1;
    checks++;
    if (ia.BUSY_VEC !== 8'h00 || ia.OUT1 !== 8'h42)
      $display("FAIL busy_cleared: got vec %h out1 %h want 00/42", ia.BUSY_VEC, ia.OUT1);
    else passed++;
    ia.ISSUE_EN = 1; ia.ISSUEaddr = 6; ia.WRITE_EN = 1; ia.INaddr = 6; ia.IN = 8'hC3;
    tick();
    ia.ISSUE_EN = 0; ia.WRITE_EN = 0; ia.OUT2addr = 6;
    #1;
    checks++;
    if (ia.BUSY_VEC !== 8'h40 || ia.BUSY2 !== 1'b1 || ia.OUT2 !== 8'hC3)
      $display("FAIL issue_write_same: got vec %h busy2 %b out2 %h want 40/1/c3",
               ia.BUSY_VEC, ia.BUSY2, ia.OUT2);
    else passed++;
    ia.ISSUE_EN = 1; ia.ISSUEaddr = 1; ia.WRITE_EN = 1; ia.INaddr = 6; ia.IN = 8'h77;
    tick();
    ia.ISSUE_EN = 0; ia.WRITE_EN = 0;
    #1;
    checks++;
    if (ia.BUSY_VEC !== 8'h02 || ia.OUT2 !== 8'h77)
      $display("FAIL issue_write_diff: got vec %h out2 %h want 02/77", ia.BUSY_VEC, ia.OUT2);
    else passed++;
  endtask

  task automatic test_reset_mid();
    ia.WRITE_EN = 1; ia.INaddr = 1; ia.IN = 8'h55; ia.ISSUE_EN = 1; ia.ISSUEaddr = 1;
    tick();
    ia.OUT1addr = 1; ia.OUT2addr = 2;
    ia.WRITE_EN = 0; ia.ISSUE_EN = 0;
    #1;
    checks++;
    if (ia.OUT1 !== 8'h55 || ia.BUSY_VEC !== 8'h02)
      $display("FAIL mid_setup: got out1 %h vec %h want 55/02", ia.OUT1, ia.BUSY_VEC);
    else passed++;
    rst_a = 1; ia.WRITE_EN = 1; ia.INaddr = 1; ia.IN = 8'hFF; ia.ISSUE_EN = 1; ia.ISSUEaddr = 2;
    rst_b = 1; ib.WRITE_EN = 1; ib.INaddr = 3; ib.IN = 8'hFF; ib.OUT1addr = 3;
    #1;
    checks++;
    if (ia.OUT1 !== 8'h55)
      $display("FAIL mid_no_bypass_in_reset: got %h want 55", ia.OUT1);
    else passed++;
    tick();
    #1;
    checks++;
    if (ia.OUT1 !== 8'h00 || ia.BUSY_VEC !== 8'h00 || ia.BUSY2 !== 1'b0)
      $display("FAIL mid_reset_a: got out1 %h vec %h want 00/00", ia.OUT1, ia.BUSY_VEC);
    else passed++;
    checks++;
    if (ib.OUT1 !== 8'h88)
      $display("FAIL mid_reset_b: got %h want 88", ib.OUT1);
    else passed++;
    rst_a = 0; rst_b = 0;
    ia.WRITE_EN = 0; ia.ISSUE_EN = 0; ib.WRITE_EN = 0;
    tick();
  endtask

  task automatic test_zero_reg();
    ic.WRITE_EN = 1; ic.INaddr = 0; ic.IN = 16'hBEEF;
    ic.ISSUE_EN = 1; ic.ISSUEaddr = 0; ic.OUT1addr = 0;
    #1;
    checks++;
    if (ic.OUT1 !== 16'h0000)
      $display("FAIL zero_no_bypass: got %h want 0000", ic.OUT1);
    else passed++;
    tick();
    ic.WRITE_EN = 0; ic.ISSUE_EN = 0;
    #1;
    checks++;
    if (ic.OUT1 !== 16'h0000 || ic.BUSY_VEC !== 16'h0000 || ic.BUSY1 !== 1'b0)
      $display("FAIL zero_reg: got out1 %h vec %h want 0000/0000", ic.OUT1, ic.BUSY_VEC);
    else passed++;
    ic.WRITE_EN = 1; ic.INaddr = 15; ic.IN = 16'hBEEF; ic.OUT2addr = 15;
    ic.ISSUE_EN = 1; ic.ISSUEaddr = 15;
    #1;
    checks++;
    if (ic.OUT2 !== 16'hBEEF)
      $display("FAIL r15_bypass: got %h want beef", ic.OUT2);
    else passed++;
    tick();
    ic.WRITE_EN = 0; ic.ISSUE_EN = 0;
    #1;
    checks++;
    if (ic.OUT2 !== 16'hBEEF || ic.BUSY_VEC !== 16'h8000)
      $display("FAIL r15_store: got %h vec %h want beef/8000", ic.OUT2, ic.BUSY_VEC);
    else passed++;
    // r8 differs from r0 only in the top address bit.
    ic.WRITE_EN = 1; ic.INaddr = 8; ic.IN = 16'h1234;
    tick();
    ic.WRITE_EN = 0; ic.OUT1addr = 8; ic.OUT2addr = 0;
    #1;
    checks++;
    if (ic.OUT1 !== 16'h1234 || ic.OUT2 !== 16'h0000)
      $display("FAIL full_addr: got %h/%h want 1234/0000", ic.OUT1, ic.OUT2);
    else passed++;
  endtask

  initial begin
    rst_a = 0; rst_b = 0; rst_c = 0;
    idle_all();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    test_zero_reg();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
